// File: rtl/echo_ind_pkg.sv
// Shared types and constants for the Echo indication serializer.
// Covers the FIFO entry layout, the header word fields and the serializer state encoding.
package echo_ind_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned SEQ_W       = 8;
    localparam int unsigned HDR_SEQ_LSB = 24;
    localparam int unsigned HDR_LEN_LSB = 16;
    localparam int unsigned HDR_ID_BIT  = 0;

    localparam logic             ID_HEARD  = 1'b0;
    localparam logic             ID_HEARD2 = 1'b1;
    localparam logic [SEQ_W-1:0] MSG_LEN   = 8'd2;

    localparam logic [0:0] S_HDR  = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] payload;
    } ind_entry_t;

    // Header word: [31:24] sequence, [23:16] length, [0] method id.
    function automatic logic [DATA_W-1:0] make_header(input logic [SEQ_W-1:0] seq,
                                                      input logic             id);
        logic [DATA_W-1:0] hdr;
        hdr                          = '0;
        hdr[HDR_SEQ_LSB +: SEQ_W]    = seq;
        hdr[HDR_LEN_LSB +: SEQ_W]    = MSG_LEN;
        hdr[HDR_ID_BIT]              = id;
        return hdr;
    endfunction

endpackage

// File: rtl/echo_indication_serializer_if.sv
// Word pipe toward the host transport.
// The serializer is the master and the transport is the slave.
interface echo_indication_serializer_if;
    import echo_ind_pkg::*;

    logic              enq__ENA;
    logic [DATA_W-1:0] enq__v;
    logic              enq__last;
    logic              enq__RDY;

    modport master (output enq__ENA, output enq__v, output enq__last, input  enq__RDY);
    modport slave  (input  enq__ENA, input  enq__v, input  enq__last, output enq__RDY);

endinterface

// File: rtl/echo_ind_fifo.sv
// Message FIFO with two ordered push ports (push0 lands before push1) and one pop port.
// The head entry is visible the cycle after it is written.
module echo_ind_fifo
    import echo_ind_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push0,
    input  ind_entry_t       push0_data,
    input  logic             push1,
    input  ind_entry_t       push1_data,
    input  logic             pop,
    output ind_entry_t       head,
    output logic [CNT_W-1:0] count
);

    ind_entry_t       mem_q [DEPTH];
    ind_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // Second push goes to the slot after the first one when both fire.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_1 = wr_ptr_q + PTR_W'(push0);
        do_pop   = pop && (count_q != '0);
        if (push0) mem_d[wr_ptr_q] = push0_data;
        if (push1) mem_d[wr_ptr_1] = push1_data;
        wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/echo_indication_serializer.sv
// Accepts heard/heard2 indications into a FIFO and serializes each one as a
// header word followed by a payload word on the host word pipe.
module echo_indication_serializer
    import echo_ind_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  heard__ENA,
    input  logic [DATA_W-1:0]     heard__v,
    output logic                  heard__RDY,
    input  logic                  heard2__ENA,
    input  logic [15:0]           heard2__a,
    input  logic [15:0]           heard2__b,
    output logic                  heard2__RDY,
    echo_indication_serializer_if.master pipe,
    output logic [CNT_WIDTH-1:0]  sent_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [0:0]           state_q, state_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic [CNT_WIDTH-1:0] sent_count_q, sent_count_d;

    logic [CNT_W-1:0] fifo_count;
    ind_entry_t       head;
    ind_entry_t       heard_entry;
    ind_entry_t       heard2_entry;
    logic             accept_rdy;
    logic             push0;
    logic             push1;
    logic             pop;
    logic             empty;

    // Acceptance needs room for a worst-case double push; depends on registered count only.
    always_comb begin
        accept_rdy   = (CNT_W'(DEPTH) - fifo_count) >= CNT_W'(2);
        empty        = (fifo_count == '0);
        push0        = heard__ENA && accept_rdy;
        push1        = heard2__ENA && accept_rdy;
        heard_entry  = '{id: ID_HEARD,  payload: heard__v};
        heard2_entry = '{id: ID_HEARD2, payload: {heard2__a, heard2__b}};
    end

    echo_ind_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (CLK),
        .rst_n      (nRST),
        .push0      (push0),
        .push0_data (heard_entry),
        .push1      (push1),
        .push1_data (heard2_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

    // Serializer next-state and word pipe outputs.
    always_comb begin
        state_d        = state_q;
        seq_d          = seq_q;
        sent_count_d   = sent_count_q;
        pop            = 1'b0;
        pipe.enq__ENA  = 1'b0;
        pipe.enq__v    = '0;
        pipe.enq__last = 1'b0;
        if (state_q == S_HDR) begin
            pipe.enq__ENA = !empty;
            if (!empty) begin
                pipe.enq__v = make_header(seq_q, head.id);
                if (pipe.enq__RDY) state_d = S_BODY;
            end
        end else begin
            pipe.enq__ENA  = 1'b1;
            pipe.enq__v    = head.payload;
            pipe.enq__last = 1'b1;
            if (pipe.enq__RDY) begin
                pop          = 1'b1;
                seq_d        = seq_q + SEQ_W'(1);
                sent_count_d = sent_count_q + CNT_WIDTH'(1);
                state_d      = S_HDR;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= S_HDR;
            seq_q        <= '0;
            sent_count_q <= '0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            sent_count_q <= sent_count_d;
        end
    end

    assign heard__RDY  = accept_rdy;
    assign heard2__RDY = accept_rdy;
    assign sent_count  = sent_count_q;

endmodule

// File: tb/tb_echo_indication_serializer.sv
// Scoreboard bench for echo_indication_serializer: a message-level model predicts
// the word stream, acceptance and sent count; a monitor compares every cycle.
module tb_echo_indication_serializer;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned CNT_WIDTH = 16;

    logic        clk;
    logic        nrst;
    logic        heard_ena;
    logic [31:0] heard_v;
    logic        heard_rdy;
    logic        heard2_ena;
    logic [15:0] heard2_a;
    logic [15:0] heard2_b;
    logic        heard2_rdy;
    logic [CNT_WIDTH-1:0] sent_count;

    echo_indication_serializer_if pipe ();

    echo_indication_serializer #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .CLK         (clk),
        .nRST        (nrst),
        .heard__ENA  (heard_ena),
        .heard__v    (heard_v),
        .heard__RDY  (heard_rdy),
        .heard2__ENA (heard2_ena),
        .heard2__a   (heard2_a),
        .heard2__b   (heard2_b),
        .heard2__RDY (heard2_rdy),
        .pipe        (pipe),
        .sent_count  (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic        last;
    } word_t;

    word_t exp_q[$];
    int    acc_msgs;
    int    done_msgs;
    int    exp_sent;
    int    total;
    int    bad;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // A message becomes two words; its sequence number is its index since reset.
    task automatic push_msg(input logic id, input logic [31:0] payload);
        word_t w;
        w.v    = ((acc_msgs % 256) << 24) | (2 << 16) | 32'(id);
        w.last = 1'b0;
        exp_q.push_back(w);
        w.v    = payload;
        w.last = 1'b1;
        exp_q.push_back(w);
        acc_msgs++;
    endtask

    // Monitor: samples 1ns before each rising edge, inputs settled since the falling edge.
    always @(negedge clk) begin
        #4;
        if (!nrst) begin
            exp_q.delete();
            acc_msgs  = 0;
            done_msgs = 0;
            exp_sent  = 0;
        end else begin : mon
            int    occ;
            logic  rdy;
            word_t w;
            occ = acc_msgs - done_msgs;
            rdy = (int'(DEPTH) - occ) >= 2;
            check("heard_rdy",  32'(heard_rdy),  32'(rdy));
            check("heard2_rdy", 32'(heard2_rdy), 32'(rdy));
            check("sent_count", 32'(sent_count), 32'(exp_sent % 65536));
            check("enq_ena",    32'(pipe.enq__ENA), 32'(exp_q.size() != 0));
            if (pipe.enq__ENA && exp_q.size() != 0) begin
                w = exp_q[0];
                check("enq_v",    pipe.enq__v,         w.v);
                check("enq_last", 32'(pipe.enq__last), 32'(w.last));
                if (pipe.enq__RDY) begin
                    void'(exp_q.pop_front());
                    if (w.last) begin
                        done_msgs++;
                        exp_sent++;
                    end
                end
            end
            if (heard_ena && rdy)  push_msg(1'b0, heard_v);
            if (heard2_ena && rdy) push_msg(1'b1, {heard2_a, heard2_b});
        end
    end

    task automatic drive(input logic h, input logic [31:0] v, input logic h2,
                         input logic [15:0] a, input logic [15:0] b, input logic rdy);
        @(negedge clk);
        #1;
        heard_ena     = h;
        heard_v       = v;
        heard2_ena    = h2;
        heard2_a      = a;
        heard2_b      = b;
        pipe.enq__RDY = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 16'h0, 16'h0, rdy);
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++)
            drive(($urandom % 3) == 0, $urandom, ($urandom % 3) == 0,
                  16'($urandom), 16'($urandom), ($urandom % 4) != 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nrst  = 1'b0;
        heard_ena = 1'b0; heard_v = '0; heard2_ena = 1'b0; heard2_a = '0; heard2_b = '0;
        pipe.enq__RDY = 1'b1;
        idle(3, 1'b1);
        nrst = 1'b1;

        // Single heard, then heard2, then both in one cycle.
        drive(1'b1, 32'hDEADBEEF, 1'b0, 16'h0, 16'h0, 1'b1);
        idle(4, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 16'h1234, 16'h5678, 1'b1);
        idle(4, 1'b1);
        drive(1'b1, 32'hCAFEF00D, 1'b1, 16'hA5A5, 16'h5A5A, 1'b1);
        idle(6, 1'b1);

        // Backpressure: fill to 3, further calls dropped, then drain.
        drive(1'b1, 32'h11111111, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 16'h2222, 16'h3333, 1'b0);
        drive(1'b1, 32'h44444444, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 32'h55555555, 1'b1, 16'h6666, 16'h7777, 1'b0);
        idle(2, 1'b0);
        idle(12, 1'b1);

        // Long random run; carries the sequence number past 255.
        random_traffic(3000);
        idle(12, 1'b1);

        // Reset while a payload word is stalled with entries still queued.
        drive(1'b1, 32'h88888888, 1'b1, 16'h9999, 16'hAAAA, 1'b0);
        drive(1'b1, 32'hBBBBBBBB, 1'b0, 16'h0, 16'h0, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        @(negedge clk);
        #1;
        nrst = 1'b0;
        @(negedge clk);
        #1;
        nrst = 1'b1;
        drive(1'b1, 32'h0BADF00D, 1'b0, 16'h0, 16'h0, 1'b1);
        idle(4, 1'b1);
        random_traffic(200);
        idle(20, 1'b1);

        @(negedge clk);
        #2;
        check("drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
